// File: rtl/shift_operand_stage.sv
// Two-entry issue FIFO in front of the left shifter; precomputes effective shift amount and kill.
// Define SHIFT_AMT_SAT_EN to saturate amt at 31 (and force kill) when the unwrapped sum overflows.
module shift_operand_stage #(
   parameter int DW    = 32,
   parameter int TW    = 4,
   parameter int DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_value1,
   input  logic [DW-1:0] in_value2,
   input  logic [3:0]    in_shift_hex,
   input  logic [TW-1:0] in_dest,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] value1,
   output logic [DW-1:0] value2,
   output logic [3:0]    shift_hex,
   output logic          EN,
   output logic [TW-1:0] out_dest,
   output logic [4:0]    out_amt,
   output logic          out_kill
);

   typedef struct packed {
      logic [DW-1:0] value1;
      logic [DW-1:0] value2;
      logic [3:0]    shift_hex;
      logic [TW-1:0] dest;
      logic [4:0]    amt;
      logic          kill;
   } entry_t;

`ifdef SHIFT_AMT_SAT_EN
   localparam int SW = 6;
`else
   localparam int SW = 5;
`endif
   localparam logic [1:0] FULL = 2'(DEPTH);

   entry_t        mem_q [2];
   entry_t        mem_d [2];
   entry_t        head_q, head_d;
   entry_t        in_entry;
   logic [1:0]    count_q, count_d;
   logic          rd_ptr_q, rd_ptr_d;
   logic          wr_ptr_q, wr_ptr_d;
   logic [SW-1:0] amt_sum;
   logic          push, pop;

   always_comb begin
      in_entry           = '0;
      in_entry.value1    = in_value1;
      in_entry.value2    = in_value2;
      in_entry.shift_hex = in_shift_hex;
      in_entry.dest      = in_dest;
      // A zero register amount selects the immediate-only form hex+1.
      if (in_value2[4:0] == 5'd0)
         amt_sum = SW'(in_shift_hex) + SW'(1);
      else
         amt_sum = SW'(in_value2[4:0]) + SW'(in_shift_hex);
      in_entry.amt  = amt_sum[4:0];
      in_entry.kill = |in_value2[DW-1:5];
`ifdef SHIFT_AMT_SAT_EN
      if (amt_sum > SW'(31)) begin
         in_entry.amt  = 5'd31;
         in_entry.kill = 1'b1;
      end
`endif
   end

   assign in_ready  = (count_q < FULL);
   assign out_valid = (count_q != 2'd0);
   assign EN        = out_valid;
   assign push      = in_valid & in_ready & ~flush;
   assign pop       = out_valid & out_ready & ~flush;

   always_comb begin
      mem_d[0] = mem_q[0];
      mem_d[1] = mem_q[1];
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (flush) begin
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = in_entry;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop)
            rd_ptr_d = ~rd_ptr_q;
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
      // Head register only follows the FIFO while it is non-empty, so an empty stage holds the last op.
      head_d = (count_d != 2'd0) ? mem_d[rd_ptr_d] : head_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         head_q   <= '0;
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         mem_q[0] <= mem_d[0];
         mem_q[1] <= mem_d[1];
         head_q   <= head_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
   end

   assign value1    = head_q.value1;
   assign value2    = head_q.value2;
   assign shift_hex = head_q.shift_hex;
   assign out_dest  = head_q.dest;
   assign out_amt   = head_q.amt;
   assign out_kill  = head_q.kill;

endmodule
